// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding,
// opcode/function constants, ALU operation codes and datapath select codes.
package mc_pkg;

    // Controller states; the 4-bit encoding is also exported on state_o.
    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DCD   = 4'd1,
        S_EXE   = 4'd2,
        S_ALUWB = 4'd3,
        S_MA    = 4'd4,
        S_MR    = 4'd5,
        S_MEMWB = 4'd6,
        S_MW    = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9,
        S_TRAP  = 4'd10
    } state_e;

    // Instruction classes produced by the decoder.
    typedef enum logic [3:0] {
        CLS_R_ALU   = 4'd0,
        CLS_I_ALU   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BEQ     = 4'd4,
        CLS_BNE     = 4'd5,
        CLS_J       = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JR      = 4'd8,
        CLS_ILLEGAL = 4'd9
    } iclass_e;

    // Primary opcodes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes.
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU operation codes (ALU_LUI passes operand B through).
    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;
    localparam logic [3:0] ALU_LUI  = 4'd13;

    // Next-PC selects.
    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_REG    = 2'd3;

    // Immediate extension selects.
    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    // Destination register selects.
    localparam logic [1:0] REG_RD = 2'd0;
    localparam logic [1:0] REG_RT = 2'd1;
    localparam logic [1:0] REG_RA = 2'd2;

    // Write-data selects.
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    // Trap causes.
    localparam logic [1:0] EXC_NONE    = 2'd0;
    localparam logic [1:0] EXC_ILLEGAL = 2'd1;
    localparam logic [1:0] EXC_MEM_TO  = 2'd2;

    // Logical immediates are zero-extended, lui goes to the upper half,
    // everything else is sign-extended.
    function automatic logic [1:0] ext_for_op(input logic [5:0] op);
        logic [1:0] ext;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: ext = EXT_ZERO;
            OP_LUI:                   ext = EXT_UPPER;
            default:                  ext = EXT_SIGN;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps op/func to an instruction class,
// the ALU operation for EXE, a shift flag and an illegal-instruction flag.
module mc_decode
    import mc_pkg::*;
#(
    parameter int SHIFT_EN = 1
) (
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_e    cls,
    output logic [3:0] alu_op,
    output logic       is_shift,
    output logic       illegal
);

    // Classify the instruction and pick its ALU operation.
    always_comb begin
        cls      = CLS_ILLEGAL;
        alu_op   = ALU_ADDU;
        is_shift = 1'b0;
        case (op)
            OP_RTYPE: begin
                cls = CLS_R_ALU;
                case (func)
                    FN_ADDU: alu_op = ALU_ADDU;
                    FN_SUBU: alu_op = ALU_SUBU;
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_JR:   cls    = CLS_JR;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // Shifts exist only in builds that include the shifter.
                        if (SHIFT_EN != 0) begin
                            is_shift = 1'b1;
                            if (func == FN_SLL) begin
                                alu_op = ALU_SLL;
                            end else if (func == FN_SRL) begin
                                alu_op = ALU_SRL;
                            end else begin
                                alu_op = ALU_SRA;
                            end
                        end else begin
                            cls = CLS_ILLEGAL;
                        end
                    end
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI:  begin cls = CLS_I_ALU; alu_op = ALU_ADD;  end
            OP_ADDIU: begin cls = CLS_I_ALU; alu_op = ALU_ADDU; end
            OP_SLTI:  begin cls = CLS_I_ALU; alu_op = ALU_SLT;  end
            OP_SLTIU: begin cls = CLS_I_ALU; alu_op = ALU_SLTU; end
            OP_ANDI:  begin cls = CLS_I_ALU; alu_op = ALU_AND;  end
            OP_ORI:   begin cls = CLS_I_ALU; alu_op = ALU_OR;   end
            OP_XORI:  begin cls = CLS_I_ALU; alu_op = ALU_XOR;  end
            OP_LUI:   begin cls = CLS_I_ALU; alu_op = ALU_LUI;  end
            OP_LW:    cls = CLS_LOAD;
            OP_SW:    cls = CLS_STORE;
            OP_BEQ:   cls = CLS_BEQ;
            OP_BNE:   cls = CLS_BNE;
            OP_J:     cls = CLS_J;
            OP_JAL:   cls = CLS_JAL;
            default:  cls = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/mc_ctrl_v2.sv
// Multi-cycle MIPS-style controller. State, wait counter and trap cause are
// registered; all control outputs are decoded combinationally from the
// current state and the live op/func/zero/mem_ready inputs.
module mc_ctrl_v2
    import mc_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int SHIFT_EN    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               pc_wr,
    output logic               ir_wr,
    output logic               rf_wr,
    output logic               dm_wr,
    output logic [1:0]         ext_sel,
    output logic [1:0]         npc_op,
    output logic [1:0]         reg_sel,
    output logic [1:0]         wd_sel,
    output logic               b_sel,
    output logic               a_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               exc,
    output logic [1:0]         exc_cause,
    output logic [3:0]         state_o
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;

    iclass_e    dec_cls_s;
    logic [3:0] dec_alu_op_s;
    logic       dec_shift_s;
    logic       dec_illegal_s;
    logic       timeout_s;
    logic       enter_wait_s;

    mc_decode #(
        .SHIFT_EN (SHIFT_EN)
    ) u_decode (
        .op       (op),
        .func     (func),
        .cls      (dec_cls_s),
        .alu_op   (dec_alu_op_s),
        .is_shift (dec_shift_s),
        .illegal  (dec_illegal_s)
    );

    // A pending access has run out of budget; mem_ready this cycle still wins.
    assign timeout_s = (cnt_q == CNT_MAX) && !mem_ready;

    // Next-state logic and combinational control outputs.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        mem_req   = 1'b0;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        rf_wr     = 1'b0;
        dm_wr     = 1'b0;
        ext_sel   = EXT_ZERO;
        npc_op    = NPC_PC4;
        reg_sel   = REG_RD;
        wd_sel    = WD_ALU;
        b_sel     = 1'b0;
        a_sel     = 1'b0;
        alu_op    = ALUOP_W'(ALU_ADDU);
        exc       = 1'b0;
        exc_cause = EXC_NONE;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    pc_wr   = 1'b1;
                    ir_wr   = 1'b1;
                    npc_op  = NPC_PC4;
                    state_d = S_DCD;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = EXC_MEM_TO;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DCD: begin
                ext_sel = ext_for_op(op);
                if (dec_illegal_s) begin
                    state_d = S_TRAP;
                    cause_d = EXC_ILLEGAL;
                end else begin
                    case (dec_cls_s)
                        CLS_R_ALU, CLS_I_ALU:   state_d = S_EXE;
                        CLS_LOAD, CLS_STORE:    state_d = S_MA;
                        CLS_BEQ, CLS_BNE:       state_d = S_BR;
                        CLS_J, CLS_JAL, CLS_JR: state_d = S_JMP;
                        default: begin
                            state_d = S_TRAP;
                            cause_d = EXC_ILLEGAL;
                        end
                    endcase
                end
            end
            S_EXE: begin
                b_sel   = (dec_cls_s == CLS_I_ALU);
                a_sel   = dec_shift_s;
                alu_op  = ALUOP_W'(dec_alu_op_s);
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rf_wr   = 1'b1;
                wd_sel  = WD_ALU;
                reg_sel = (dec_cls_s == CLS_I_ALU) ? REG_RT : REG_RD;
                state_d = S_FETCH;
            end
            S_MA: begin
                b_sel   = 1'b1;
                ext_sel = EXT_SIGN;
                alu_op  = ALUOP_W'(ALU_ADDU);
                state_d = (dec_cls_s == CLS_STORE) ? S_MW : S_MR;
            end
            S_MR: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = EXC_MEM_TO;
                end else begin
                    state_d = S_MR;
                end
            end
            S_MEMWB: begin
                rf_wr   = 1'b1;
                reg_sel = REG_RT;
                wd_sel  = WD_MEM;
                state_d = S_FETCH;
            end
            S_MW: begin
                mem_req = 1'b1;
                dm_wr   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = EXC_MEM_TO;
                end else begin
                    state_d = S_MW;
                end
            end
            S_BR: begin
                alu_op  = ALUOP_W'(ALU_SUBU);
                b_sel   = 1'b0;
                npc_op  = NPC_BRANCH;
                pc_wr   = (dec_cls_s == CLS_BNE) ? !zero : zero;
                state_d = S_FETCH;
            end
            S_JMP: begin
                pc_wr = 1'b1;
                case (dec_cls_s)
                    CLS_J:  npc_op = NPC_JUMP;
                    CLS_JAL: begin
                        npc_op  = NPC_JUMP;
                        rf_wr   = 1'b1;
                        reg_sel = REG_RA;
                        wd_sel  = WD_PC;
                    end
                    CLS_JR: npc_op = NPC_REG;
                    default: npc_op = NPC_JUMP;
                endcase
                state_d = S_FETCH;
            end
            S_TRAP: begin
                exc       = 1'b1;
                exc_cause = cause_q;
                state_d   = S_TRAP;
            end
            default: begin
                // Unreachable encodings fail safe into the trap state.
                state_d = S_TRAP;
                cause_d = EXC_ILLEGAL;
            end
        endcase
    end

    // The wait counter restarts when a memory-waiting state is entered.
    assign enter_wait_s = (state_d != state_q) &&
                          ((state_d == S_FETCH) || (state_d == S_MR) || (state_d == S_MW));

    // Wait counter: clear on entry or completion, count stalled request cycles.
    always_comb begin
        if (enter_wait_s || mem_ready) begin
            cnt_d = '0;
        end else if (mem_req && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, wait counter and trap cause registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= EXC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/mc_ctrl_v2.md
MC_CTRL_V2 -- requirements
Module: mc_ctrl_v2

Interface
REQ-001 Parameter ALUOP_W, default 4, width of alu_op.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum wait cycles for mem_ready before trap.
REQ-003 Parameter SHIFT_EN, default 1; when 0, shift functions decode as illegal.
REQ-004 clk  input  1  clock; rst  input  1  reset, asynchronous, active-high.
REQ-005 op  input  6  instruction opcode; func  input  6  R-type function field.
REQ-006 zero  input  1  ALU zero flag, combinational, valid in BR state.
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 mem_req  output  1  memory access request (instruction or data).
REQ-009 pc_wr, ir_wr, rf_wr, dm_wr  output  1 each  write enables.
REQ-010 ext_sel  output  2  0 zero-ext, 1 sign-ext, 2 upper (imm<<16).
REQ-011 npc_op  output  2  0 PC+4, 1 branch, 2 jump, 3 register (rs).
REQ-012 reg_sel  output  2  0 rd, 1 rt, 2 $31; wd_sel  output  2  0 ALU, 1 MEM, 2 PC.
REQ-013 b_sel  output  1  0 rt, 1 extended imm; a_sel  output  1  0 rs, 1 shamt.
REQ-014 alu_op  output  ALUOP_W  ALU operation code (package encoding).
REQ-015 exc  output  1  trap active; exc_cause  output  2  0 none, 1 illegal, 2 mem timeout.
REQ-016 state_o  output  4  current state, for debug.

Function
REQ-017 States: FETCH, DCD, EXE, ALUWB, MA, MR, MEMWB, MW, BR, JMP, TRAP; registered state, all outputs combinational from state, op, func, zero, mem_ready.
REQ-018 Every output defaults to 0 in every state unless set below; no latches.
REQ-019 FETCH: mem_req=1; wait while mem_ready=0; on mem_ready=1 assert pc_wr, ir_wr, npc_op=0 that cycle and go to DCD.
REQ-020 DCD: ext_sel=0 for ori/andi/xori, 2 for lui, else 1; go EXE (R-type ALU/shift, I-type ALU incl. lui, slti), MA (lw/sw), BR (beq/bne), JMP (j/jal/jr), TRAP with cause 1 otherwise.
REQ-021 Supported R funcs: addu subu add sub and or xor nor slt sltu jr, plus sll srl sra when SHIFT_EN=1; any other func is illegal.
REQ-022 EXE: b_sel=1 for I-type, a_sel=1 for sll/srl/sra, alu_op per package table; always go ALUWB.
REQ-023 ALUWB: rf_wr=1, wd_sel=0, reg_sel=1 for I-type else 0; go FETCH.
REQ-024 MA: b_sel=1, ext_sel=1, alu_op=ADDU; go MR (lw) or MW (sw).
REQ-025 MR: mem_req=1; on mem_ready go MEMWB. MEMWB: rf_wr=1, reg_sel=1, wd_sel=1; go FETCH.
REQ-026 MW: mem_req=1, dm_wr=1 held until mem_ready; on mem_ready go FETCH.
REQ-027 BR: alu_op=SUBU, b_sel=0, npc_op=1, pc_wr=zero for beq, pc_wr=~zero for bne; go FETCH.
REQ-028 JMP: pc_wr=1; j: npc_op=2; jal: npc_op=2, rf_wr=1, reg_sel=2, wd_sel=2; jr: npc_op=3; go FETCH.
REQ-029 Wait counter (width ceil(log2(MEM_TIMEOUT+1))) clears on entering FETCH/MR/MW and on mem_ready; increments each cycle mem_req=1 and mem_ready=0.
REQ-030 Counter reaching MEM_TIMEOUT with mem_ready=0 goes to TRAP, cause 2; mem_ready=1 in that same cycle wins (normal completion).
REQ-031 TRAP: exc=1, exc_cause held, all write enables 0, mem_req=0; state held until rst.
REQ-032 op/func sampled only in DCD and later states; IR holds them stable after FETCH.

Reset
REQ-033 rst asserted: state=FETCH, counter=0, exc_cause=0 immediately, independent of clk.
REQ-034 rst mid-access aborts the access; first cycle after release is FETCH with mem_req=1.

Structure
REQ-035 Shared package mc_pkg: state encoding, opcode/func constants, ALU op codes, npc/ext/reg/wd select codes.
REQ-036 One sub-module mc_decode: combinational op/func to instruction class, alu_op, illegal flag.

Verification
REQ-037 addu $3,$1,$2 with mem_ready always 1 -> FETCH,DCD,EXE,ALUWB; rf_wr=1 reg_sel=0 in cycle 4; 4 cycles total.
REQ-038 lw with mem_ready low 3 cycles in MR -> MR lasts 4 cycles, then MEMWB rf_wr=1 wd_sel=1.
REQ-039 bne with zero=0 -> BR pc_wr=1 npc_op=1; beq with zero=0 -> pc_wr=0.
REQ-040 jal -> JMP pc_wr=1 rf_wr=1 reg_sel=2 wd_sel=2; jr -> npc_op=3, rf_wr=0.
REQ-041 op=6'h3F -> TRAP, exc=1 exc_cause=1; SHIFT_EN=0 and sll -> same trap.
REQ-042 mem_ready stuck low in FETCH, MEM_TIMEOUT=15 -> TRAP cause 2 after 16 FETCH cycles; rst then -> FETCH, exc=0.
